// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave sequencing controller: state codes and default widths.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int W_DEF = 4;

endpackage

// File: rtl/microwave_if.sv
// Front-panel / driver bundle: panel pulses and settings in, timer and driver enables out.
interface microwave_if
    import microwave_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         tick;
    logic         start;
    logic         stop;
    logic         door_open;
    logic [W-1:0] tin;
    logic [1:0]   pwr;
    logic [W-1:0] remaining;
    logic [1:0]   state;
    logic         mag_on;
    logic         lamp;
    logic         beep;
    logic         busy;

    modport master (
        output tick, start, stop, door_open, tin, pwr,
        input  remaining, state, mag_on, lamp, beep, busy
    );

    modport slave (
        input  tick, start, stop, door_open, tin, pwr,
        output remaining, state, mag_on, lamp, beep, busy
    );

endinterface

// File: rtl/mw_time_reg.sv
// Remaining-time register: load, saturating increment, decrement and clear, with a one-second-left flag.
module mw_time_reg
    import microwave_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         one_left
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (inc) begin
            if (q != '1) q <= q + W'(1);
        end else if (dec) begin
            // Never wraps below zero even if a stray dec arrives
            if (q != '0) q <= q - W'(1);
        end
    end

    assign one_left = (q == W'(1));

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencing FSM: cook-time countdown, door/stop pause, magnetron duty cycling, end beep.
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int DUTY_PERIOD = 4,
    parameter int BEEP_TICKS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    microwave_if.slave  bus
);

    localparam int DW = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [DW-1:0] DUTY_LAST = DW'(DUTY_PERIOD - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_t        st;
    logic [DW-1:0] duty_cnt;
    logic [DW-1:0] duty_nxt;
    logic [BW-1:0] beep_cnt;
    logic          beep_q;
    logic          t_load, t_inc, t_dec, t_clr;
    logic [W-1:0]  remaining;
    logic          one_left;

    assign duty_nxt = (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + DW'(1);

    mw_time_reg #(.W(W)) u_time (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .inc      (t_inc),
        .dec      (t_dec),
        .clr      (t_clr),
        .din      (bus.tin),
        .q        (remaining),
        .one_left (one_left)
    );

    always_comb begin
        t_load = 1'b0;
        t_inc  = 1'b0;
        t_dec  = 1'b0;
        t_clr  = 1'b0;
        case (st)
            ST_IDLE:  t_load = bus.start && !bus.door_open && (bus.tin != '0);
            ST_COOK: begin
                // Pause wins; start+tick cancels out and leaves the time untouched
                if (!(bus.door_open || bus.stop)) begin
                    if (bus.start && !bus.tick)      t_inc = 1'b1;
                    else if (bus.tick && !bus.start) begin
                        if (one_left) t_clr = 1'b1;
                        else          t_dec = 1'b1;
                    end
                end
            end
            ST_PAUSE: t_clr = bus.stop;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            duty_cnt <= '0;
            beep_cnt <= '0;
            beep_q   <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bus.start && !bus.door_open && (bus.tin != '0)) begin
                        st       <= ST_COOK;
                        duty_cnt <= '0;
                    end
                end
                ST_COOK: begin
                    if (bus.door_open || bus.stop) begin
                        st <= ST_PAUSE;
                    end else if (bus.tick) begin
                        if (!bus.start && one_left) begin
                            st       <= ST_DONE;
                            beep_cnt <= '0;
                            beep_q   <= 1'b1;
                        end else begin
                            duty_cnt <= duty_nxt;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.stop)                          st <= ST_IDLE;
                    else if (bus.start && !bus.door_open)  st <= ST_COOK;
                end
                ST_DONE: begin
                    if (bus.stop || bus.door_open) begin
                        st     <= ST_IDLE;
                        beep_q <= 1'b0;
                    end else if (bus.tick) begin
                        beep_cnt <= beep_cnt + BW'(1);
                        if (beep_cnt == BEEP_LAST) begin
                            st     <= ST_IDLE;
                            beep_q <= 1'b0;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Door gating is combinational so the magnetron drops in the cycle the door opens
    assign bus.mag_on    = (st == ST_COOK) && !bus.door_open &&
                           ({{(32-DW){1'b0}}, duty_cnt} <= {30'd0, bus.pwr});
    assign bus.lamp      = bus.door_open || (st == ST_COOK);
    assign bus.busy      = (st == ST_COOK) || (st == ST_PAUSE);
    assign bus.state     = st;
    assign bus.remaining = remaining;
    assign bus.beep      = beep_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed-vector bench for microwave_ctrl with hand-computed expectations.
module tb_microwave_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    microwave_if bus ();

    microwave_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply pulses for one clock edge, then sample 1 ns after it
    task automatic cyc(input logic s_start, input logic s_stop, input logic s_tick);
        bus.start = s_start;
        bus.stop  = s_stop;
        bus.tick  = s_tick;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
    endtask

    logic [7:0] pat1;
    logic [3:0] pat0;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
        bus.door_open = 1'b0;
        bus.tin   = 4'd0;
        bus.pwr   = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_rem",   32'(bus.remaining), 0);
        chk("rst_beep",  32'(bus.beep), 0);
        chk("rst_mag",   32'(bus.mag_on), 0);
        chk("rst_lamp",  32'(bus.lamp), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        rst = 1'b0;

        // Basic cook at full power
        bus.tin = 4'd3; bus.pwr = 2'd3;
        cyc(1, 0, 0);
        chk("t1_state", 32'(bus.state), 1);
        chk("t1_rem3",  32'(bus.remaining), 3);
        chk("t1_mag0",  32'(bus.mag_on), 1);
        chk("t1_busy",  32'(bus.busy), 1);
        chk("t1_lamp",  32'(bus.lamp), 1);
        cyc(0, 0, 1);
        chk("t1_rem2",  32'(bus.remaining), 2);
        chk("t1_mag1",  32'(bus.mag_on), 1);
        cyc(0, 0, 1);
        chk("t1_rem1",  32'(bus.remaining), 1);
        chk("t1_mag2",  32'(bus.mag_on), 1);
        cyc(0, 0, 1);
        chk("t1_done",  32'(bus.state), 3);
        chk("t1_rem0",  32'(bus.remaining), 0);
        chk("t1_beep",  32'(bus.beep), 1);
        chk("t1_magd",  32'(bus.mag_on), 0);
        cyc(0, 0, 1);
        chk("t1_bk1",   32'(bus.state), 3);
        cyc(0, 0, 1);
        chk("t1_bk2",   32'(bus.beep), 1);
        cyc(0, 0, 1);
        chk("t1_idle",  32'(bus.state), 0);
        chk("t1_beep0", 32'(bus.beep), 0);

        // Door opens on a tick: magnetron drops immediately, remaining held
        bus.tin = 4'd5;
        cyc(1, 0, 0);
        chk("t2_rem5",  32'(bus.remaining), 5);
        bus.door_open = 1'b1;
        bus.tick      = 1'b1;
        #1;
        chk("t2_magcomb", 32'(bus.mag_on), 0);
        chk("t2_lamp",    32'(bus.lamp), 1);
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
        chk("t2_pause", 32'(bus.state), 2);
        chk("t2_hold",  32'(bus.remaining), 5);
        cyc(1, 0, 0);
        chk("t2_doorst", 32'(bus.state), 2);
        bus.door_open = 1'b0;
        cyc(1, 0, 0);
        chk("t2_resume", 32'(bus.state), 1);
        chk("t2_rem",    32'(bus.remaining), 5);

        // Pause and cancel
        cyc(0, 0, 1);
        chk("t3_rem4",  32'(bus.remaining), 4);
        cyc(0, 1, 0);
        chk("t3_pause", 32'(bus.state), 2);
        chk("t3_hold",  32'(bus.remaining), 4);
        cyc(0, 0, 1);
        chk("t3_tickig", 32'(bus.remaining), 4);
        cyc(0, 1, 0);
        chk("t3_idle",  32'(bus.state), 0);
        chk("t3_rem0",  32'(bus.remaining), 0);
        chk("t3_busy",  32'(bus.busy), 0);
        bus.tin = 4'd4;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("t3_p2",    32'(bus.state), 2);
        cyc(1, 1, 0);
        chk("t3_ssidle", 32'(bus.state), 0);
        chk("t3_ssrem",  32'(bus.remaining), 0);

        // Add time, saturation, start+tick cancel
        bus.tin = 4'd15;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("t4_sat",   32'(bus.remaining), 15);
        cyc(0, 0, 1);
        chk("t4_dec",   32'(bus.remaining), 14);
        cyc(1, 0, 0);
        chk("t4_add",   32'(bus.remaining), 15);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        bus.tin = 4'd1;
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("t4_st1",   32'(bus.remaining), 1);
        chk("t4_cook",  32'(bus.state), 1);
        cyc(0, 0, 1);
        chk("t4_done",  32'(bus.state), 3);
        bus.door_open = 1'b1;
        cyc(0, 0, 0);
        chk("t4_doorid", 32'(bus.state), 0);
        chk("t4_beep0",  32'(bus.beep), 0);
        bus.door_open = 1'b0;

        // Duty windows at pwr=1 and pwr=0
        pat1 = 8'b0011_0011;
        pat0 = 4'b0001;
        bus.pwr = 2'd1; bus.tin = 4'd8;
        cyc(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_p1_%0d", i), 32'(bus.mag_on), 32'(pat1[i]));
            cyc(0, 0, 1);
        end
        chk("t5_done1", 32'(bus.state), 3);
        cyc(0, 1, 0);
        bus.pwr = 2'd0; bus.tin = 4'd4;
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_p0_%0d", i), 32'(bus.mag_on), 32'(pat0[i]));
            cyc(0, 0, 1);
        end
        chk("t5_done0", 32'(bus.state), 3);
        cyc(0, 1, 0);

        // Ignored starts, then asynchronous reset mid-cook
        bus.pwr = 2'd3; bus.tin = 4'd0;
        cyc(1, 0, 0);
        chk("t6_tin0", 32'(bus.state), 0);
        bus.tin = 4'd5; bus.door_open = 1'b1;
        cyc(1, 0, 0);
        chk("t6_door", 32'(bus.state), 0);
        bus.door_open = 1'b0;
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        chk("t6_rem4", 32'(bus.remaining), 4);
        chk("t6_mag",  32'(bus.mag_on), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_st",  32'(bus.state), 0);
        chk("t6_rst_rem", 32'(bus.remaining), 0);
        chk("t6_rst_mag", 32'(bus.mag_on), 0);
        chk("t6_rst_bsy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 1);
        chk("t6_post", 32'(bus.state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Sequencing controller for the microwave timer/magnetron datapath. It loads a cook time, counts it down on a 1 s tick enable, and pauses on door-open or stop. It duty-cycles the magnetron according to a power level and beeps on completion. It sits between the front-panel pulse synchroniser and the magnetron/lamp/buzzer drivers.

Parameters:
W, 4, width of cook-time setting and remaining-time register
DUTY_PERIOD, 4, ticks per magnetron duty window; power level p enables the first p+1 ticks of each window
BEEP_TICKS, 3, number of ticks the buzzer stays on in DONE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-cycle enable pulse, once per second
start  in  1  one-cycle pulse: start, resume, or add 1 s
stop  in  1  one-cycle pulse: pause, or cancel
door_open  in  1  door switch level, 1 = open
tin  in  W  cook time setting in seconds
pwr  in  2  power level 0..3
remaining  out  W  seconds left, registered
state  out  2  current state code
mag_on  out  1  magnetron enable
lamp  out  1  cavity lamp
beep  out  1  buzzer, registered
busy  out  1  1 in COOK or PAUSE

Behaviour:
- Reset (asynchronous, on rst=1): state=IDLE, remaining=0, duty_cnt=0, beep_cnt=0, beep=0. mag_on, lamp and busy follow from state and door_open; with door closed they are 0.
- States: IDLE=0, COOK=1, PAUSE=2, DONE=3. All transitions take effect on the next clk edge.
- IDLE:
  - start & !door_open & tin!=0 -> COOK; remaining<=tin; duty_cnt<=0.
  - start with tin==0 or door_open is ignored.
  - stop has no effect.
- COOK, evaluated in priority order:
  1. door_open or stop -> PAUSE. remaining and duty_cnt are held; a same-cycle tick is discarded.
  2. start & tick -> remaining unchanged (+1 and -1 cancel); duty_cnt advances.
  3. start -> remaining<=min(remaining+1, 2^W-1), saturating.
  4. tick & remaining==1 -> remaining<=0; go to DONE; beep_cnt<=0.
  5. tick -> remaining<=remaining-1; duty_cnt<=(duty_cnt==DUTY_PERIOD-1)?0:duty_cnt+1.
- PAUSE:
  - stop -> IDLE; remaining<=0 (cancel). stop beats a same-cycle start.
  - start & !door_open -> COOK, resuming with the held remaining and duty_cnt.
  - start while door_open is ignored.
  - tick is ignored.
- DONE:
  - beep=1.
  - Each tick increments beep_cnt; the tick on which beep_cnt==BEEP_TICKS-1 -> IDLE, beep<=0.
  - stop or door_open -> IDLE immediately; beep<=0.
  - start is ignored.
- mag_on = (state==COOK) & !door_open & (duty_cnt<=pwr). The door gating is combinational so that the magnetron drops in the same cycle the door opens (safety interlock). At pwr=3 with DUTY_PERIOD=4 the magnetron is always on.
- lamp = door_open | (state==COOK), combinational.
- busy = (state==COOK)|(state==PAUSE).
- remaining never underflows. It reaches 0 only through the DONE transition or a cancel.
- Inputs: start, stop and tick are single-cycle pulses already synchronised to clk; door_open is a synchronised level.
- Reset asserted mid-cook: the block returns to IDLE immediately and mag_on falls asynchronously with state.

Decomposition:
- Shared package microwave_pkg holds:
  - state codes ST_IDLE/ST_COOK/ST_PAUSE/ST_DONE (2-bit)
  - default W
- One sub-module, mw_time_reg. It is the W-bit remaining-time register with async reset and controls load / dec / inc-saturate / clear, plus a one_left flag. It is driven by the FSM in microwave_ctrl.
- duty_cnt and beep_cnt stay inline.

Test Plan:
1. Basic cook: tin=3, pwr=3, start, then 3 ticks. Required: COOK for 3 ticks with remaining 3->2->1->0; DONE and beep=1 on the 3rd tick; IDLE after 3 more ticks; mag_on=1 throughout COOK.
2. Door interlock: during COOK with remaining=5, raise door_open coincident with a tick. Required: mag_on=0 in the same cycle; PAUSE with remaining=5; lamp=1. Close the door and pulse start: COOK resumes at 5.
3. Cancel: COOK remaining=4, stop -> PAUSE with remaining=4; second stop -> IDLE with remaining=0 and busy=0. start and stop in the same cycle in PAUSE -> IDLE.
4. Add time and saturation: COOK remaining=15 (W=4), start -> remaining stays 15. At remaining=1, start+tick together -> remaining=1 and state stays COOK.
5. Power duty: pwr=1, DUTY_PERIOD=4, tin=8. Required: mag_on pattern per tick window 1,1,0,0,1,1,0,0. pwr=0 gives 1,0,0,0.
6. Ignored starts and async reset: start with tin=0 or door_open in IDLE -> stays IDLE. Assert rst mid-COOK (between clk edges) -> state=IDLE, remaining=0, mag_on=0 immediately.
